scroll_ctrl: RTL and testbench
==============================

// Module: scroll_ctrl
// PURPOSE
//  Frame-synchronous scroll/offset controller for the background layer address transformer.
//  Game logic issues commands over a valid/ready port: speed, lane offset, pause and resume.
//  Commands are staged in shadow registers. They are applied only at the start of vertical
//  blanking, so hoffset/voffset never change mid-frame (no tearing).
//  Outputs drive the transformer's hoffset/voffset inputs directly.
// PARAMETERS
//  OFFW     12   width of hoffset/voffset/cmd_arg
//  IMG_W    160  background image width in px; hoffset range 0..IMG_W-1
//  IMG_H    120  background image height in px; voffset wraps modulo IMG_H
//  V_ACTIVE 480  vdata value of the first blanking line (frame boundary)
// PORTS
//  clk         in   1     system clock (one clock domain)
//  rst         in   1     synchronous, active-high reset
//  vdata       in   12    current line from vga timing generator
//  cmd_valid   in   1     command present
//  cmd_ready   out  1     controller can accept a command this cycle
//  cmd_op      in   2     00 SET_VSPEED, 01 SET_HOFF, 10 PAUSE, 11 RESUME
//  cmd_arg     in   OFFW  operand for ops 00/01; ignored for 10/11
//  hoffset     out  OFFW  horizontal offset to transformer
//  voffset     out  OFFW  vertical scroll offset to transformer
//  running     out  1     1 while scrolling is enabled (state RUN)
//  frame_pulse out  1     1-cycle strobe when new offsets become visible
//  frame_cnt   out  16    count of scrolled frames; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=1, synchronous, dominant over all other inputs):
//   - state=IDLE; hoffset=voffset=0; running=0; frame_pulse=0; frame_cnt=0.
//   - Shadow registers: vspd_sh=0, hoff_sh=0, run_sh=0. vdata_q=0.
//   - cmd_ready=0 while rst=1. Commands presented during reset are dropped.
//  Frame boundary: fb = (vdata==V_ACTIVE) && (vdata_q!=V_ACTIVE), where vdata_q is vdata
//   registered each cycle. Exactly one fb per frame; a held vdata gives no repeat.
//  Handshake: a command is accepted when cmd_valid && cmd_ready at a clock edge.
//   - cmd_ready = !rst && state!=APPLY (deasserted only for the 1-cycle APPLY state).
//   - SET_VSPEED: vspd_sh <= min(cmd_arg, IMG_H-1).
//   - SET_HOFF: hoff_sh <= min(cmd_arg, IMG_W-1).
//   - PAUSE: run_sh <= 0.  RESUME: run_sh <= 1.
//   - When several commands are accepted within one frame, the last write to each field wins.
//  FSM states IDLE, RUN, APPLY:
//   - IDLE/RUN --fb--> APPLY. With no fb the state holds.
//   - APPLY (1 cycle): hoffset<=hoff_sh.
//     If run_sh: voffset <= (voffset+vspd_sh) mod IMG_H, computed OFFW+1 bits wide,
//     with a single conditional subtract of IMG_H; frame_cnt <= frame_cnt+1.
//     If !run_sh: voffset and frame_cnt hold.
//     frame_pulse <= 1. Next state = run_sh ? RUN : IDLE.
//   - running = (state==RUN). Registered output, updated as APPLY exits.
//  Latency: fb true in cycle t -> APPLY in t+1 -> new hoffset/voffset and frame_pulse=1 in t+2.
//   frame_pulse=0 in t+3.
//  Simultaneous events:
//   - A command accepted in the same cycle as fb is written to shadow in that cycle.
//     It therefore takes effect in the APPLY of that same frame.
//   - fb cannot occur in APPLY: the earliest next fb is one full frame later.
//  Wrap-around: with voffset=IMG_H-1 and vspd_sh=1, the next APPLY gives voffset=0.
//   vspd_sh=0 while running: offsets hold, but frame_cnt still increments.
//  Reset mid-operation: rst in any state, including APPLY, returns to reset values on the next
//   edge. Any in-flight update is discarded and frame_pulse is not emitted.
//  Outputs are registered and change only in APPLY or under reset; hoffset/voffset are stable
//   for the entire active frame.
// TESTING
//  1 Reset then 3 frames, no commands -> hoffset=voffset=0, running=0, frame_pulse=1 each frame,
//    frame_cnt=0.
//  2 RESUME + SET_VSPEED 7, 20 frames -> voffset sequence 7,14,...,119,6 (wraps at 120);
//    frame_cnt=20.
//  3 SET_VSPEED 500 -> clamped to 119; SET_HOFF 200 -> hoffset=159 after the next frame boundary.
//  4 SET_HOFF 40 accepted in the same cycle as fb -> hoffset=40 at t+2;
//    cmd_valid held at t+1 -> cmd_ready=0 for that cycle, accepted at t+2.
//  5 Running at speed 5: PAUSE mid-frame -> voffset still advances at current fb? no:
//    PAUSE lands in shadow, so the next APPLY holds voffset and running=0.
//    RESUME -> advance resumes one frame later.
//  6 rst asserted during APPLY -> t+1: all outputs 0, no frame_pulse;
//    cmd_ready=0 while rst=1, then 1.

Source files
------------

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: frame-synchronous scroll offsets; commands staged in shadow regs, applied at vblank start
module scroll_ctrl #(
  parameter int OFFW     = 12,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int V_ACTIVE = 480
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     vdata,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [OFFW-1:0] cmd_arg,
  output logic [OFFW-1:0] hoffset,
  output logic [OFFW-1:0] voffset,
  output logic            running,
  output logic            frame_pulse,
  output logic [15:0]     frame_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, APPLY} state_t;
  state_t state, state_nx;
  logic [11:0] vdata_q;
  logic [OFFW-1:0] vspd_sh, hoff_sh;
  logic run_sh, fb, acc;
  logic [OFFW:0] vsum, vnext;
  assign fb = vdata == 12'(V_ACTIVE) && vdata_q != 12'(V_ACTIVE);
  assign cmd_ready = !rst && state != APPLY;
  assign acc = cmd_valid && cmd_ready;
  assign running = state == RUN;
  // both operands are below IMG_H, so one conditional subtract is a full modulo
  assign vsum = {1'b0, voffset} + {1'b0, vspd_sh};
  assign vnext = vsum >= (OFFW+1)'(IMG_H) ? vsum - (OFFW+1)'(IMG_H) : vsum;
  always_comb begin
    state_nx = state;
    if (state == APPLY) state_nx = run_sh ? RUN : IDLE;
    else if (fb) state_nx = APPLY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vdata_q     <= '0;
      vspd_sh     <= '0;
      hoff_sh     <= '0;
      run_sh      <= 1'b0;
      hoffset     <= '0;
      voffset     <= '0;
      frame_pulse <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nx;
      vdata_q     <= vdata;
      frame_pulse <= state == APPLY;
      if (acc) begin
        case (cmd_op)
          2'b00: vspd_sh <= cmd_arg > OFFW'(IMG_H-1) ? OFFW'(IMG_H-1) : cmd_arg;
          2'b01: hoff_sh <= cmd_arg > OFFW'(IMG_W-1) ? OFFW'(IMG_W-1) : cmd_arg;
          2'b10: run_sh <= 1'b0;
          default: run_sh <= 1'b1;
        endcase
      end
      if (state == APPLY) begin
        hoffset <= hoff_sh;
        if (run_sh) begin
          voffset   <= vnext[OFFW-1:0];
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: random + directed stimulus checked every cycle against a frame-level reference model
module tb_scroll_ctrl;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready, running, frame_pulse;
  logic [11:0] vdata = 0, hoffset, voffset, cmd_arg = 0;
  logic [1:0] cmd_op = 0;
  logic [15:0] frame_cnt;
  int checks = 0, failures = 0;
  int m_vspd, m_hoff, m_run, m_h, m_v, m_cnt, m_pulse, m_rs, m_apply, m_prev;
  scroll_ctrl dut (.clk(clk), .rst(rst), .vdata(vdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .hoffset(hoffset), .voffset(voffset), .running(running),
    .frame_pulse(frame_pulse), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  task automatic chk(string tag, int unsigned got, int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    int vspd, hoff, run, h, v, cnt, pulse, rs, apply;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, (!rst && !m_apply) ? 1 : 0);
    chk("hoffset", hoffset, m_h);
    chk("voffset", voffset, m_v);
    chk("running", running, (!m_apply && m_rs) ? 1 : 0);
    chk("frame_pulse", frame_pulse, m_pulse);
    chk("frame_cnt", frame_cnt, m_cnt);
    {vspd, hoff, run, h, v, cnt, rs, apply} = {m_vspd, m_hoff, m_run, m_h, m_v, m_cnt, m_rs, m_apply};
    pulse = 0;
    if (rst) {vspd, hoff, run, h, v, cnt, rs, apply} = '0;
    else begin
      if (cmd_valid && !m_apply)
        case (cmd_op)
          0: vspd = cmd_arg > 119 ? 119 : cmd_arg;
          1: hoff = cmd_arg > 159 ? 159 : cmd_arg;
          2: run = 0;
          3: run = 1;
        endcase
      if (m_apply) begin
        h = m_hoff;
        if (m_run) begin
          v = (m_v + m_vspd) % 120;
          cnt = (m_cnt + 1) % 65536;
        end
        pulse = 1;
        rs = m_run;
        apply = 0;
      end else if (vdata == 480 && m_prev != 480) apply = 1;
    end
    @(posedge clk);
    #1;
    {m_vspd, m_hoff, m_run, m_h, m_v, m_cnt, m_pulse, m_rs, m_apply} =
      {vspd, hoff, run, h, v, cnt, pulse, rs, apply};
    m_prev = rst ? 0 : int'(vdata);
  endtask
  task automatic send(int op, int arg);
    cmd_valid = 1; cmd_op = 2'(op); cmd_arg = 12'(arg); vdata = 12'd5;
    cycle();
    cmd_valid = 0;
  endtask
  task automatic do_reset();
    rst = 1; cmd_valid = 1; cmd_op = 2'd3; cmd_arg = 12'd50;
    repeat (2) cycle();
    rst = 0; cmd_valid = 0;
    cycle();
  endtask
  // mode 0: no commands, 1: random commands, 2: command on fb and held into APPLY, 3: rst in APPLY
  task automatic frames(int n, int mode);
    for (int f = 0; f < n; f++)
      for (int l = 0; l < 16; l++) begin
        vdata = (l >= 10 && l < 13) ? 12'd480 : 12'($urandom_range(0, 479));
        if (mode == 1) begin
          cmd_valid = $urandom_range(0, 3) == 0;
          cmd_op = 2'($urandom);
          cmd_arg = $urandom_range(0, 1) ? 12'($urandom_range(0, 200)) : 12'($urandom);
        end
        if (mode == 2) begin
          cmd_valid = l == 10 || l == 11; cmd_op = 2'd1; cmd_arg = 12'd40;
        end
        if (mode == 3) rst = l == 11;
        cycle();
        if (mode == 2 && l == 12) chk("hoff_on_fb", hoffset, 40);
      end
    cmd_valid = 0; rst = 0;
  endtask
  initial begin
    {m_vspd, m_hoff, m_run, m_h, m_v, m_cnt, m_pulse, m_rs, m_apply, m_prev} = '0;
    do_reset();
    frames(3, 0);
    chk("idle_cnt", frame_cnt, 0);
    send(3, 0); send(0, 7);
    frames(20, 0);
    chk("wrap_voff", voffset, 20);
    chk("wrap_cnt", frame_cnt, 20);
    send(0, 500); send(1, 200);
    frames(1, 0);
    chk("clamp_h", hoffset, 159);
    chk("clamp_v", voffset, (20 + 119) % 120);
    frames(2, 2);
    send(0, 5);
    frames(1, 0);
    send(2, 0);
    frames(1, 0);
    chk("pause_run", running, 0);
    send(3, 0);
    frames(2, 0);
    chk("resume_run", running, 1);
    frames(1, 3);
    chk("rst_apply_cnt", frame_cnt, 0);
    frames(1, 0);
    for (int i = 0; i < 30; i++) frames(1, 1);
    do_reset();
    frames(40, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
